// File: rtl/load_unit.sv
// load_unit: sequential load path from the LSU issue stage to a word-wide
// data-memory port. A load issues one word read, or two when it straddles a
// word boundary. The returned beats are merged and shifted, then sign- or
// zero-extended per funct3. The result is handed back over a valid/ready
// handshake.
//
// Build option: LOAD_UNIT_MISALIGNED_SPLIT_EN
//   defined   - word-crossing loads are split into two reads and merged.
//   undefined - word-crossing loads fault without touching memory.
module load_unit #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_fault,
   input  logic              rsp_ready
);

   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);

`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

   state_t           state;
   logic [OFF_W-1:0] off_q;
   logic [2:0]       funct3_q;
   logic [TAG_W-1:0] tag_q;

   logic [OFF_W-1:0] req_off;
   logic             req_fault;
   logic [XLEN-1:0]  data_single;

`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
   logic [XLEN-1:0]  beat0_q;
   logic [XLEN-1:0]  data_pair;
   logic             cur_cross;
`else
   logic             req_cross;
`endif

   // Reserved funct3 encodings, plus the 64-bit loads on a 32-bit datapath.
   function automatic logic illegal_f3(input logic [2:0] f3);
      return (f3 == 3'b111) ||
             ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
   endfunction

   // True when the access spills past the end of the addressed word.
   function automatic logic crosses(input logic [OFF_W-1:0] off,
                                    input logic [2:0]       f3);
      int unsigned size_bytes;
      size_bytes = 32'd1 << f3[1:0];
      return (32'(off) + size_bytes) > BYTES;
   endfunction

   // Align the addressed bytes to bit 0, then sign- or zero-fill the upper part.
   function automatic logic [XLEN-1:0] extend(input logic [2*XLEN-1:0] combined,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [2:0]        f3);
      logic [2*XLEN-1:0] shifted_full;
      logic [XLEN-1:0]   shifted;
      logic [XLEN-1:0]   result;
      logic              fill;
      int unsigned       nbits;
      shifted_full = combined >> {off, 3'b000};
      shifted      = shifted_full[XLEN-1:0];
      case (f3[1:0])
         2'd0:    begin nbits = 8;    fill = shifted[7];      end
         2'd1:    begin nbits = 16;   fill = shifted[15];     end
         2'd2:    begin nbits = 32;   fill = shifted[31];     end
         default: begin nbits = XLEN; fill = shifted[XLEN-1]; end
      endcase
      fill = fill & ~f3[2];
      for (int unsigned i = 0; i < XLEN; i++) begin
         result[i] = (i < nbits) ? shifted[i] : fill;
      end
      return result;
   endfunction

   // Request decode and result formatting, ahead of the state register.
   assign req_ready   = (state == IDLE);
   assign req_off     = req_addr[OFF_W-1:0];
   assign data_single = extend({{XLEN{1'b0}}, mem_rdata}, off_q, funct3_q);
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
   assign req_fault   = illegal_f3(req_funct3);
   assign cur_cross   = crosses(off_q, funct3_q);
   assign data_pair   = extend({mem_rdata, beat0_q}, off_q, funct3_q);
`else
   assign req_cross   = crosses(req_off, req_funct3);
   assign req_fault   = illegal_f3(req_funct3) || req_cross;
`endif

   // Load sequencer: memory handshakes, beat capture and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_fault <= 1'b0;
         off_q     <= '0;
         funct3_q  <= '0;
         tag_q     <= '0;
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
         beat0_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  off_q    <= req_off;
                  funct3_q <= req_funct3;
                  tag_q    <= req_tag;
                  if (req_fault) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_data  <= '0;
                     rsp_tag   <= req_tag;
                     rsp_fault <= 1'b1;
                  end else begin
                     state    <= REQ0;
                     mem_req  <= 1'b1;
                     mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  end
               end
            end
            REQ0: begin
               if (mem_gnt) begin
                  state   <= WAIT0;
                  mem_req <= 1'b0;
               end
            end
            WAIT0: begin
               if (mem_rvalid) begin
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
                  beat0_q <= mem_rdata;
                  if (cur_cross) begin
                     state    <= REQ1;
                     mem_req  <= 1'b1;
                     mem_addr <= mem_addr + ADDR_W'(BYTES);
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_data  <= data_single;
                     rsp_tag   <= tag_q;
                     rsp_fault <= 1'b0;
                  end
`else
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= data_single;
                  rsp_tag   <= tag_q;
                  rsp_fault <= 1'b0;
`endif
               end
            end
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
            REQ1: begin
               if (mem_gnt) begin
                  state   <= WAIT1;
                  mem_req <= 1'b0;
               end
            end
            WAIT1: begin
               if (mem_rvalid) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= data_pair;
                  rsp_tag   <= tag_q;
                  rsp_fault <= 1'b0;
               end
            end
`endif
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
